clock_set_ctrl: RTL and testbench



---
 rtl/clock_set_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Time-keeping and time-setting controller for the electronic clock.
//   Keeps the live hh:mm:ss counter running from tick_1hz. A set-mode FSM
//   edits a shadow copy of the time, which is then committed to the live
//   counter or discarded. Drives the display mux with the digit values, the
//   selected field and a blink control for that field.
//
//   Optional build macro: CLOCK_SET_TIMEOUT_EN
//     When defined, TIMEOUT_SEC seconds without a key press in a set state
//     abandon the edit (same effect as CANCEL).
//
// Parameters:
//   BLINK_HALF   clk cycles per blink half-period
//   TIMEOUT_SEC  tick_1hz pulses of key inactivity before auto-cancel
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   key_pulse     one-cycle key events: [0] MODE [1] INC [2] DEC [3] CANCEL [4] OK
//   tick_1hz      one-cycle enable, once per second
//   disp_hour     hour shown (0..23)
//   disp_min      minute shown (0..59)
//   disp_sec      second shown (0..59)
//   field_sel     0 none, 1 hour, 2 minute, 3 second
//   field_blank   1 = blank the selected field
//   commit_pulse  one-cycle pulse when the shadow time is loaded into live time

module clock_set_ctrl #(
    parameter int unsigned BLINK_HALF  = 25000000,
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key_pulse,
    input  logic       tick_1hz,
    output logic [4:0] disp_hour,
    output logic [5:0] disp_min,
    output logic [5:0] disp_sec,
    output logic [1:0] field_sel,
    output logic       field_blank,
    output logic       commit_pulse
);

    // State codes double as the field_sel value.
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOUR = 2'd1;
    localparam logic [1:0] ST_MIN  = 2'd2;
    localparam logic [1:0] ST_SEC  = 2'd3;

    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [1:0]    state, nxt_state;
    logic [4:0]    live_h, live_m_dummy_unused;
    logic [5:0]    live_m, live_s;
    logic [4:0]    sh_h;
    logic [5:0]    sh_m, sh_s;
    logic [BW-1:0] blink_cnt, nxt_blink_cnt;
    logic          nxt_blank;

    logic [4:0]    nxt_live_h, nxt_sh_h, tick_h;
    logic [5:0]    nxt_live_m, nxt_live_s, nxt_sh_m, nxt_sh_s, tick_m, tick_s;
    logic          commit, blink_clear;
    logic          in_set;

    // Fixed key priority: CANCEL > OK > MODE > INC > DEC.
    logic act_cancel, act_ok, act_mode, act_inc, act_dec;
    assign act_cancel = key_pulse[3];
    assign act_ok     = !key_pulse[3] && key_pulse[4];
    assign act_mode   = !key_pulse[3] && !key_pulse[4] && key_pulse[0];
    assign act_inc    = !key_pulse[3] && !key_pulse[4] && !key_pulse[0] && key_pulse[1];
    assign act_dec    = !key_pulse[3] && !key_pulse[4] && !key_pulse[0] && !key_pulse[1]
                        && key_pulse[2];

    assign in_set = (state != ST_RUN);
    assign live_m_dummy_unused = '0;

    function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] top,
                                             input logic up);
        if (up)
            return (v == top) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    logic [5:0] hour_adj, min_adj, sec_adj;
    assign hour_adj = step_wrap({1'b0, sh_h}, 6'd23, act_inc);
    assign min_adj  = step_wrap(sh_m, 6'd59, act_inc);
    assign sec_adj  = step_wrap(sh_s, 6'd59, act_inc);

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_SEC - 1);
    logic [TW-1:0] to_cnt, nxt_to_cnt;
    logic          timeout_hit;
    assign timeout_hit = tick_1hz && (to_cnt == TO_LAST);
`endif

    // Live counter advanced by one second, with carries.
    always_comb begin
        tick_h = live_h;
        tick_m = live_m;
        tick_s = live_s + 6'd1;
        if (live_s == 6'd59) begin
            tick_s = '0;
            tick_m = live_m + 6'd1;
            if (live_m == 6'd59) begin
                tick_m = '0;
                tick_h = (live_h == 5'd23) ? 5'd0 : live_h + 5'd1;
            end
        end
    end

    always_comb begin
        nxt_state   = state;
        nxt_sh_h    = sh_h;
        nxt_sh_m    = sh_m;
        nxt_sh_s    = sh_s;
        commit      = 1'b0;
        blink_clear = 1'b0;

        if (in_set) begin
            if (act_cancel) begin
                nxt_state = ST_RUN;
            end else if (act_ok) begin
                nxt_state = ST_RUN;
                commit    = 1'b1;
            end else if (act_mode) begin
                blink_clear = 1'b1;
                if (state == ST_SEC) begin
                    nxt_state = ST_RUN;
                    commit    = 1'b1;
                end else begin
                    nxt_state = state + 2'd1;
                end
            end else if (act_inc || act_dec) begin
                blink_clear = 1'b1;
                case (state)
                    ST_HOUR: nxt_sh_h = hour_adj[4:0];
                    ST_MIN:  nxt_sh_m = min_adj;
                    default: nxt_sh_s = sec_adj;
                endcase
`ifdef CLOCK_SET_TIMEOUT_EN
            end else if (timeout_hit) begin
                nxt_state = ST_RUN;
`endif
            end
        end else if (act_mode) begin
            nxt_state   = ST_HOUR;
            nxt_sh_h    = live_h;
            nxt_sh_m    = live_m;
            nxt_sh_s    = live_s;
            blink_clear = 1'b1;
        end

        // Commit overrides a coincident tick.
        if (commit) begin
            nxt_live_h = sh_h;
            nxt_live_m = sh_m;
            nxt_live_s = sh_s;
        end else if (tick_1hz) begin
            nxt_live_h = tick_h;
            nxt_live_m = tick_m;
            nxt_live_s = tick_s;
        end else begin
            nxt_live_h = live_h;
            nxt_live_m = live_m;
            nxt_live_s = live_s;
        end

        if (nxt_state == ST_RUN || blink_clear) begin
            nxt_blink_cnt = '0;
            nxt_blank     = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            nxt_blink_cnt = '0;
            nxt_blank     = !field_blank;
        end else begin
            nxt_blink_cnt = blink_cnt + 1'b1;
            nxt_blank     = field_blank;
        end

`ifdef CLOCK_SET_TIMEOUT_EN
        // Any key in a set state is accepted, so any key restarts the count.
        if (nxt_state == ST_RUN || (|key_pulse))
            nxt_to_cnt = '0;
        else if (tick_1hz)
            nxt_to_cnt = to_cnt + 1'b1;
        else
            nxt_to_cnt = to_cnt;
`endif
    end

    // Outputs are registered from the next-state values so every response
    // is visible right after the edge that consumed the key or tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            live_h       <= '0;
            live_m       <= '0;
            live_s       <= '0;
            sh_h         <= '0;
            sh_m         <= '0;
            sh_s         <= '0;
            blink_cnt    <= '0;
            disp_hour    <= '0;
            disp_min     <= '0;
            disp_sec     <= '0;
            field_sel    <= '0;
            field_blank  <= 1'b0;
            commit_pulse <= 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
            to_cnt       <= '0;
`endif
        end else begin
            state        <= nxt_state;
            live_h       <= nxt_live_h;
            live_m       <= nxt_live_m;
            live_s       <= nxt_live_s;
            sh_h         <= nxt_sh_h;
            sh_m         <= nxt_sh_m;
            sh_s         <= nxt_sh_s;
            blink_cnt    <= nxt_blink_cnt;
            disp_hour    <= (nxt_state == ST_RUN) ? nxt_live_h : nxt_sh_h;
            disp_min     <= (nxt_state == ST_RUN) ? nxt_live_m : nxt_sh_m;
            disp_sec     <= (nxt_state == ST_RUN) ? nxt_live_s : nxt_sh_s;
            field_sel    <= nxt_state;
            field_blank  <= nxt_blank;
            commit_pulse <= commit;
`ifdef CLOCK_SET_TIMEOUT_EN
            to_cnt       <= nxt_to_cnt;
`endif
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
//   Self-checking bench for clock_set_ctrl. A reference model keeps live time
//   as seconds-of-day, the shadow as separate h/m/s numbers, blink as the
//   number of cycles since the last restart, and idle seconds for the
//   optional timeout (CLOCK_SET_TIMEOUT_EN).

module tb_clock_set_ctrl;

    localparam int unsigned BH = 4;
    localparam int unsigned TO = 2;

    localparam logic [4:0] K_MODE   = 5'b00001;
    localparam logic [4:0] K_INC    = 5'b00010;
    localparam logic [4:0] K_DEC    = 5'b00100;
    localparam logic [4:0] K_CANCEL = 5'b01000;
    localparam logic [4:0] K_OK     = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] key_pulse;
    logic       tick_1hz;
    logic [4:0] disp_hour;
    logic [5:0] disp_min;
    logic [5:0] disp_sec;
    logic [1:0] field_sel;
    logic       field_blank;
    logic       commit_pulse;

    clock_set_ctrl #(.BLINK_HALF(BH), .TIMEOUT_SEC(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_pulse    (key_pulse),
        .tick_1hz     (tick_1hz),
        .disp_hour    (disp_hour),
        .disp_min     (disp_min),
        .disp_sec     (disp_sec),
        .field_sel    (field_sel),
        .field_blank  (field_blank),
        .commit_pulse (commit_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = RUN, 1/2/3 = editing hour/min/sec.
    int m_state, m_live, m_sh, m_sm, m_ss, m_phase, m_idle, m_commit;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_live = 0; m_sh = 0; m_sm = 0; m_ss = 0;
        m_phase = 0; m_idle = 0; m_commit = 0;
    endtask

    task automatic model_step(input logic [4:0] k, input bit t);
        int commit, clear, accepted, fmod, fv;
        commit = 0; clear = 0; accepted = 0;
        if (m_state != 0) begin
            accepted = (k != 0);
            if (k[3]) m_state = 0;
            else if (k[4]) commit = 1;
            else if (k[0]) begin
                if (m_state == 3) commit = 1;
                else begin m_state++; clear = 1; end
            end else if (k[1] || k[2]) begin
                fmod = (m_state == 1) ? 24 : 60;
                fv = (m_state == 1) ? m_sh : (m_state == 2) ? m_sm : m_ss;
                fv = k[1] ? (fv + 1) % fmod : (fv + fmod - 1) % fmod;
                if (m_state == 1) m_sh = fv;
                else if (m_state == 2) m_sm = fv;
                else m_ss = fv;
                clear = 1;
            end
`ifdef CLOCK_SET_TIMEOUT_EN
            else if (t && (m_idle + 1 >= TO)) m_state = 0;
`endif
            if (commit != 0) m_state = 0;
        end else if (k[0] && !k[3] && !k[4]) begin
            m_state = 1;
            m_sh = m_live / 3600; m_sm = (m_live / 60) % 60; m_ss = m_live % 60;
            clear = 1; accepted = 1;
        end
        if (commit != 0) m_live = m_sh * 3600 + m_sm * 60 + m_ss;
        else if (t) m_live = (m_live + 1) % 86400;
        m_commit = commit;
        if (m_state == 0 || clear != 0) m_phase = 0; else m_phase++;
        if (m_state == 0 || accepted != 0) m_idle = 0; else if (t) m_idle++;
    endtask

    task automatic check_outputs();
        int eh, em, es;
        eh = (m_state == 0) ? m_live / 3600 : m_sh;
        em = (m_state == 0) ? (m_live / 60) % 60 : m_sm;
        es = (m_state == 0) ? m_live % 60 : m_ss;
        check_val("disp_hour", int'(disp_hour), eh);
        check_val("disp_min", int'(disp_min), em);
        check_val("disp_sec", int'(disp_sec), es);
        check_val("field_sel", int'(field_sel), m_state);
        check_val("field_blank", int'(field_blank),
                  (m_state != 0 && ((m_phase / BH) % 2) == 1) ? 1 : 0);
        check_val("commit_pulse", int'(commit_pulse), m_commit);
    endtask

    task automatic cycle(input logic [4:0] k, input bit t);
        key_pulse = k;
        tick_1hz  = t;
        @(posedge clk);
        model_step(k, t);
        #1;
        key_pulse = '0;
        tick_1hz  = 1'b0;
        check_outputs();
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_hour"}, int'(disp_hour), 0);
        check_val({tag, "_min"}, int'(disp_min), 0);
        check_val({tag, "_sec"}, int'(disp_sec), 0);
        check_val({tag, "_sel"}, int'(field_sel), 0);
        check_val({tag, "_blank"}, int'(field_blank), 0);
        check_val({tag, "_commit"}, int'(commit_pulse), 0);
    endtask

    initial begin
        logic [4:0] k;
        bit         t;
        int         r;

        rst_n = 1'b0; key_pulse = '0; tick_1hz = 1'b0;
        model_reset();
        #12;
        check_zero("reset");
        #10;
        rst_n = 1'b1;
        @(negedge clk);

        // Plain counting.
        repeat (3) cycle('0, 1'b1);
        check_val("sec_after_3_ticks", int'(disp_sec), 3);

        // Edit to 23:59:59, commit, then one tick wraps to midnight.
        cycle(K_MODE, 1'b0);
        for (int i = 0; i < 30 && m_sh != 23; i++) cycle(K_INC, 1'b0);
        cycle(K_MODE, 1'b0);
        for (int i = 0; i < 70 && m_sm != 59; i++) cycle(K_INC, 1'b0);
        cycle(K_MODE, 1'b0);
        for (int i = 0; i < 70 && m_ss != 59; i++) cycle(K_INC, 1'b0);
        cycle(K_MODE, 1'b0);
        check_val("commit_hour", int'(disp_hour), 23);
        check_val("commit_min", int'(disp_min), 59);
        check_val("commit_sec", int'(disp_sec), 59);
        check_val("commit_pulse_on", int'(commit_pulse), 1);
        cycle('0, 1'b1);
        check_val("wrap_hour", int'(disp_hour), 0);
        check_val("wrap_min", int'(disp_min), 0);
        check_val("wrap_sec", int'(disp_sec), 0);

        // Hour decrement wraps 0 -> 23, ticks during edit, OK commits.
        repeat (5) cycle('0, 1'b1);
        cycle(K_MODE, 1'b0);
        cycle(K_DEC, 1'b0);
        check_val("dec_hour", int'(disp_hour), 23);
        check_val("dec_sel", int'(field_sel), 1);
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        cycle(K_OK, 1'b0);
        check_val("ok_commit", int'(commit_pulse), 1);
        cycle('0, 1'b1);
        check_val("ok_pulse_end", int'(commit_pulse), 0);
        check_val("ok_live_hour", int'(disp_hour), 23);

        // Minute edit then CANCEL.
        cycle(K_MODE, 1'b0);
        cycle(K_MODE, 1'b0);
        for (int i = 0; i < 70 && m_sm != 10; i++) cycle(K_INC, 1'b0);
        repeat (3) cycle(K_INC, 1'b0);
        cycle(K_CANCEL, 1'b0);

        // Simultaneous keys.
        cycle(K_MODE, 1'b0);
        cycle(5'b11001, 1'b0);
        check_val("multi_cancel_sel", int'(field_sel), 0);
        repeat (3) cycle(K_MODE, 1'b0);
        cycle(5'b00110, 1'b0);
        cycle(K_CANCEL, 1'b0);

        // Blink period and restart by INC.
        cycle(K_MODE, 1'b0);
        repeat (6) cycle('0, 1'b0);
        cycle(K_INC, 1'b0);
        check_val("blink_restart", int'(field_blank), 0);
        repeat (10) cycle('0, 1'b0);
        cycle(K_CANCEL, 1'b0);

        // Idle ticks in a set state (auto-cancel when the timeout is built in).
        cycle(K_MODE, 1'b0);
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        cycle('0, 1'b0);
        cycle(K_CANCEL, 1'b0);

        // Reset in the middle of an edit.
        cycle(K_MODE, 1'b0);
        cycle(K_INC, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if (m_state == 0) begin
                r = $urandom_range(0, 9);
                k = (r < 5) ? 5'(1 << r) : 5'd0;
            end else begin
                r = $urandom_range(0, 11);
                case (r)
                    0:       k = 5'($urandom);
                    1, 2:    k = K_INC;
                    3, 4:    k = K_DEC;
                    5:       k = K_MODE;
                    default: k = '0;
                endcase
            end
            t = ($urandom_range(0, 3) == 0);
            if (m_state == 0 && k[0]) t = 1'b0;
            cycle(k, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
